ace_fetch_queue: RTL

//  Parametrised fetch-packet queue between fetch stage 1 and decode; successor to the fixed 8-wide, unbuffered f1->d0 register.
//  - Stores up to DEPTH fetch packets, each FETCH_W instructions with a prefix valid mask and a base PC.
//  - Decode drains up to DEC_W instructions per cycle from the head packet; partial drains keep a per-packet offset.
//  - Fetch sees only a registered-state ready; flush from retire empties the queue.

---
 rtl/ace_fetch_queue_pkg.sv | 22 ++
 rtl/ace_fetch_queue_if.sv | 29 ++
 rtl/ace_fetch_queue_sel.sv | 36 +++
 rtl/ace_fetch_queue.sv | 85 ++++++++
 4 files changed

// File: rtl/ace_fetch_queue_pkg.sv
// ace_fetch_pkg: shared fetch-queue default widths, fetch packet type and prefix-count helper.
package ace_fetch_pkg;
    localparam int FETCH_W = 8;
    localparam int DEC_W = 4;
    localparam int INST_W = 32;
    localparam int PC_W = 64;
    localparam int MAX_W = 64;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [FETCH_W-1:0] mask;
        logic [FETCH_W-1:0][INST_W-1:0] inst;
    } fetch_pkt_t;

    // Length of the run of ones starting at bit 0; masks are prefix-shaped so this equals popcount.
    function automatic int prefix_cnt(input logic [MAX_W-1:0] m);
        int r;
        r = 0;
        for (int i = 0; i < MAX_W; i++) r = (m[i] && r == i) ? i + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/ace_fetch_queue_if.sv
// ace_fetch_queue_if: fetch-side enqueue, decode-side lanes and retire flush of the fetch queue.
interface ace_fetch_queue_if #(
    parameter int FETCH_W = ace_fetch_pkg::FETCH_W,
    parameter int DEC_W = ace_fetch_pkg::DEC_W,
    parameter int DEPTH = 4,
    parameter int INST_W = ace_fetch_pkg::INST_W,
    parameter int PC_W = ace_fetch_pkg::PC_W
);
    logic flush_i;
    logic enq_vld_i;
    logic [PC_W-1:0] enq_pc_i;
    logic [FETCH_W-1:0] enq_mask_i;
    logic [FETCH_W*INST_W-1:0] enq_inst_i;
    logic enq_rdy_o;
    logic [DEC_W-1:0] deq_vld_o;
    logic [DEC_W*INST_W-1:0] deq_inst_o;
    logic [DEC_W*PC_W-1:0] deq_pc_o;
    logic [$clog2(DEC_W+1)-1:0] deq_cnt_i;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    modport master (
        output flush_i, enq_vld_i, enq_pc_i, enq_mask_i, enq_inst_i, deq_cnt_i,
        input enq_rdy_o, deq_vld_o, deq_inst_o, deq_pc_o, count_o
    );
    modport slave (
        input flush_i, enq_vld_i, enq_pc_i, enq_mask_i, enq_inst_i, deq_cnt_i,
        output enq_rdy_o, deq_vld_o, deq_inst_o, deq_pc_o, count_o
    );
endinterface

// File: rtl/ace_fetch_queue_sel.sv
// ace_fetchq_sel: maps the head packet and its consumed offset onto DEC_W prefix-valid decode lanes.
module ace_fetchq_sel #(
    parameter int FETCH_W = ace_fetch_pkg::FETCH_W,
    parameter int DEC_W = ace_fetch_pkg::DEC_W,
    parameter int INST_W = ace_fetch_pkg::INST_W,
    parameter int PC_W = ace_fetch_pkg::PC_W,
    localparam int OW = $clog2(FETCH_W),
    localparam int NW = $clog2(FETCH_W + 1),
    localparam int CW = $clog2(DEC_W + 1)
) (
    input logic [PC_W-1:0] pc,
    input logic [FETCH_W-1:0] mask,
    input logic [FETCH_W*INST_W-1:0] inst,
    input logic [OW-1:0] off,
    output logic [NW-1:0] n,
    output logic [CW-1:0] avail,
    output logic [DEC_W-1:0] vld,
    output logic [DEC_W*INST_W-1:0] lane_inst,
    output logic [DEC_W*PC_W-1:0] lane_pc
);
    import ace_fetch_pkg::*;

    logic [NW-1:0] rem;

    assign n = NW'(prefix_cnt(MAX_W'(mask)));
    assign rem = n - NW'(off);
    assign avail = (rem > NW'(DEC_W)) ? CW'(DEC_W) : CW'(rem);

    for (genvar j = 0; j < DEC_W; j++) begin : g_lane
        logic [OW-1:0] s;
        assign s = off + OW'(j);
        assign vld[j] = CW'(j) < avail;
        assign lane_inst[j*INST_W +: INST_W] = vld[j] ? inst[s*INST_W +: INST_W] : '0;
        assign lane_pc[j*PC_W +: PC_W] = vld[j] ? pc + (PC_W'(s) << 2) : '0;
    end
endmodule

// File: rtl/ace_fetch_queue.sv
// ace_fetch_queue: DEPTH-entry fetch-packet queue feeding decode with partial drains and retire flush.
// Defining ACE_FETCHQ_BYPASS_EN lets a packet reach decode in its arrival cycle when the queue is empty.
module ace_fetch_queue #(
    parameter int FETCH_W = ace_fetch_pkg::FETCH_W,
    parameter int DEC_W = ace_fetch_pkg::DEC_W,
    parameter int DEPTH = 4,
    parameter int INST_W = ace_fetch_pkg::INST_W,
    parameter int PC_W = ace_fetch_pkg::PC_W
) (
    input logic clock,
    input logic reset_n,
    ace_fetch_queue_if.slave q
);
    import ace_fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(FETCH_W);
    localparam int NW = $clog2(FETCH_W + 1);
    localparam int CW = $clog2(DEC_W + 1);

    logic [PC_W-1:0] pc_q [DEPTH];
    logic [FETCH_W-1:0] mask_q [DEPTH];
    logic [FETCH_W*INST_W-1:0] inst_q [DEPTH];
    logic [AW:0] rd, wr;
    logic [OW-1:0] off;
    logic empty, full, byp, h_ok, fire, pop;
    logic [PC_W-1:0] h_pc;
    logic [FETCH_W-1:0] h_mask;
    logic [FETCH_W*INST_W-1:0] h_inst;
    logic [OW-1:0] h_off;
    logic [NW-1:0] n;
    logic [CW-1:0] avail, c;

    assign empty = rd == wr;
    assign full = rd[AW-1:0] == wr[AW-1:0] && rd[AW] != wr[AW];
`ifdef ACE_FETCHQ_BYPASS_EN
    assign byp = empty & ~q.flush_i & q.enq_vld_i & |q.enq_mask_i;
`else
    assign byp = 1'b0;
`endif
    // A flushed or empty head presents a zero mask so no lane can go valid.
    assign h_ok = ~q.flush_i & ~empty;
    assign h_pc = byp ? q.enq_pc_i : pc_q[rd[AW-1:0]];
    assign h_inst = byp ? q.enq_inst_i : inst_q[rd[AW-1:0]];
    assign h_mask = byp ? q.enq_mask_i : h_ok ? mask_q[rd[AW-1:0]] : '0;
    assign h_off = h_ok ? off : '0;

    ace_fetchq_sel #(
        .FETCH_W(FETCH_W), .DEC_W(DEC_W), .INST_W(INST_W), .PC_W(PC_W)
    ) u_sel (
        .pc(h_pc), .mask(h_mask), .inst(h_inst), .off(h_off), .n(n), .avail(avail),
        .vld(q.deq_vld_o), .lane_inst(q.deq_inst_o), .lane_pc(q.deq_pc_o)
    );

    assign c = (q.deq_cnt_i > avail) ? avail : q.deq_cnt_i;
    assign pop = h_ok && NW'(off) + NW'(c) == n;
    assign fire = q.enq_vld_i & ~full & |q.enq_mask_i & ~q.flush_i & ~(byp && NW'(c) == n);
    assign q.enq_rdy_o = ~full;
    assign q.count_o = wr - rd;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd <= '0;
            wr <= '0;
            off <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
                mask_q[i] <= '0;
                inst_q[i] <= '0;
            end
        end else if (q.flush_i) begin
            rd <= wr;
            off <= '0;
        end else begin
            if (fire) begin
                pc_q[wr[AW-1:0]] <= q.enq_pc_i;
                mask_q[wr[AW-1:0]] <= q.enq_mask_i;
                inst_q[wr[AW-1:0]] <= q.enq_inst_i;
                wr <= wr + (AW+1)'(1);
            end
            if (pop) rd <= rd + (AW+1)'(1);
            off <= byp ? (fire ? OW'(c) : '0) : pop ? '0 : off + OW'(c);
        end
    end
endmodule
